adder_arbiter: RTL and testbench

- Shares one 32-bit adder datapath among NUM_REQ requesters, e.g. PC increment, branch-target calc and address generation in a multi-cycle variant of the processor.
- Round-robin arbitration with a combinational grant.
- Result is registered and held until the consumer accepts it through a valid/ready response handshake.
- One operation is accepted per cycle when the response path is free.

---
 rtl/adder_arbiter_pkg.sv | 20 ++
 rtl/adder_arbiter_rr_arbiter.sv | 31 +++
 rtl/adder_arbiter.sv | 106 ++++++++++
 tb/tb_adder_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// Shared constants and types for the round-robin shared-adder block.
package adder_arbiter_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_NUM_REQ = 4;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Response record at the default configuration; the top builds its own
  // parameter-sized copy with the same field order.
  typedef struct packed {
    logic [idx_w(DEFAULT_NUM_REQ)-1:0] id;
    logic [DEFAULT_WIDTH-1:0]          sum;
    logic                              carry;
    logic                              ovf;
  } rsp_t;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req after 'last', wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;

  // k is the priority distance from the pointer; j stays a constant index.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (en && !found && req[j] && (((int'(last) + k) % N) == j)) begin
          gnt[j] = 1'b1;
          idx    = IW'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// One adder shared by NUM_REQ requesters, round-robin granted, registered result
// with valid/ready hand-off. Define ADDER_ARBITER_SUB_EN to add per-requester subtract.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int ID_W    = idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_flat,
  input  logic [NUM_REQ*WIDTH-1:0] b_flat,
`ifdef ADDER_ARBITER_SUB_EN
  input  logic [NUM_REQ-1:0]       sub,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     rsp_ovf
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } rsp_lt;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [ID_W-1:0]  last_q, last_d, gnt_idx;
  logic             valid_q, valid_d;
  rsp_lt            rsp_q, rsp_d;
  logic             free, accept, cin;
  logic [WIDTH-1:0] a_sel, b_eff;
  logic [WIDTH:0]   sum_ext;

  assign a_arr = a_flat;
  assign b_arr = b_flat;

  // A held result frees the adder in the same cycle the consumer takes it.
  assign free = !valid_q || rsp_ready;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req  (req),
    .last (last_q),
    .en   (free && rst_n),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  assign accept = |gnt;

  always_comb begin
    a_sel = a_arr[gnt_idx];
`ifdef ADDER_ARBITER_SUB_EN
    cin   = sub[gnt_idx];
    b_eff = cin ? ~b_arr[gnt_idx] : b_arr[gnt_idx];
`else
    cin   = 1'b0;
    b_eff = b_arr[gnt_idx];
`endif
    sum_ext = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  end

  // Overflow on the effective operand covers both add and subtract.
  always_comb begin
    rsp_d   = rsp_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      valid_d   = 1'b1;
      last_d    = gnt_idx;
      rsp_d.id  = gnt_idx;
      rsp_d.sum = sum_ext[WIDTH-1:0];
      rsp_d.carry = sum_ext[WIDTH];
      rsp_d.ovf = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum_ext[WIDTH-1] != a_sel[WIDTH-1]);
    end else if (rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rsp_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      valid_q <= valid_d;
      rsp_q   <= rsp_d;
      last_q  <= last_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = rsp_q.id;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_carry = rsp_q.carry;
  assign rsp_ovf   = rsp_q.ovf;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: vector table, hand sequences, random vs model.
module tb_adder_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] req;
  logic [NR-1:0][W-1:0] a_drv, b_drv;
  logic [NR-1:0] gnt;
  logic rsp_valid, rdy;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_sum;
  logic rsp_carry, rsp_ovf;
`ifdef ADDER_ARBITER_SUB_EN
  logic [NR-1:0] sub_drv;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_drv),
    .b_flat    (b_drv),
`ifdef ADDER_ARBITER_SUB_EN
    .sub       (sub_drv),
`endif
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rdy),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_rsp(input string tag, input bit v, input int id, input logic [31:0] s,
                         input bit c, input bit o);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, ".id"},    32'(rsp_id),    32'(id));
    chk({tag, ".sum"},   rsp_sum,        s);
    chk({tag, ".carry"}, 32'(rsp_carry), 32'(c));
    chk({tag, ".ovf"},   32'(rsp_ovf),   32'(o));
  endtask

  typedef struct {
    logic [NR-1:0]        req;
    logic                 rdy;
    logic [NR-1:0][W-1:0] a, b;
    logic [NR-1:0]        egnt;
    bit                   ev;
    int                   eid;
    logic [W-1:0]         esum;
    bit                   ec, eo;
  } vec_t;

  vec_t tbl[8];
  logic [NR-1:0][W-1:0] base_a, base_b, wa, wb;

  // Reference: round-robin as "closest set request after the last winner".
  function automatic int pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++)
      if (r[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                                 output logic [31:0] sum, output bit c, output bit o);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ur = s ? ua - ub : ua + ub;
    longint sr = s ? sa - sb : sa + sb;
    logic [63:0] urv = ur;
    sum = urv[31:0];
    c   = s ? (ua >= ub) : urv[32];
    o   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  bit m_valid, m_c, m_o, s_bit;
  int m_id, m_last, g;
  logic [31:0] m_sum;
  logic [NR-1:0] egnt;

  initial begin
    rst_n = 1'b0; req = '0; rdy = 1'b0; a_drv = '0; b_drv = '0;
`ifdef ADDER_ARBITER_SUB_EN
    sub_drv = '0;
`endif
    for (int i = 0; i < NR; i++) begin
      base_a[i] = 32'(i);
      base_b[i] = 32'(10 * i);
    end
    wa = base_a; wb = base_b;
    wa[2] = 32'hFFFF_FFFF; wb[2] = 32'd1;
    tbl[0] = '{4'b1111, 1'b1, base_a, base_b, 4'b0001, 1'b1, 0, 32'd0,  1'b0, 1'b0};
    tbl[1] = '{4'b1111, 1'b1, base_a, base_b, 4'b0010, 1'b1, 1, 32'd11, 1'b0, 1'b0};
    tbl[2] = '{4'b1111, 1'b1, base_a, base_b, 4'b0100, 1'b1, 2, 32'd22, 1'b0, 1'b0};
    tbl[3] = '{4'b1111, 1'b1, base_a, base_b, 4'b1000, 1'b1, 3, 32'd33, 1'b0, 1'b0};
    tbl[4] = '{4'b1111, 1'b1, base_a, base_b, 4'b0001, 1'b1, 0, 32'd0,  1'b0, 1'b0};
    tbl[5] = '{4'b0100, 1'b1, wa, wb, 4'b0100, 1'b1, 2, 32'd0, 1'b1, 1'b0};
    wa = base_a; wb = base_b;
    wa[1] = 32'h7FFF_FFFF; wb[1] = 32'd1;
    tbl[6] = '{4'b0010, 1'b1, wa, wb, 4'b0010, 1'b1, 1, 32'h8000_0000, 1'b0, 1'b1};
    tbl[7] = '{4'b0000, 1'b1, wa, wb, 4'b0000, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1};

    // Reset state, with requests already pending.
    repeat (3) @(posedge clk);
    #1 req = 4'b1111;
    #1;
    chk("reset.gnt", 32'(gnt), 32'd0);
    chk_rsp("reset", 1'b0, 0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (tbl[v]) begin
      req = tbl[v].req; rdy = tbl[v].rdy; a_drv = tbl[v].a; b_drv = tbl[v].b;
      #2 chk($sformatf("tbl%0d.gnt", v), 32'(gnt), 32'(tbl[v].egnt));
      @(posedge clk); #1;
      chk_rsp($sformatf("tbl%0d", v), tbl[v].ev, tbl[v].eid, tbl[v].esum, tbl[v].ec, tbl[v].eo);
    end

    // Backpressure: result held, no grants, then same-cycle hand-off.
    req = 4'b1111; rdy = 1'b1; a_drv = base_a; b_drv = base_b;
    #2 chk("bp.first.gnt", 32'(gnt), 32'b0100);
    @(posedge clk); #1;
    chk_rsp("bp.first", 1'b1, 2, 32'd22, 1'b0, 1'b0);
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2 chk($sformatf("bp.hold%0d.gnt", c), 32'(gnt), 32'd0);
      @(posedge clk); #1;
      chk_rsp($sformatf("bp.hold%0d", c), 1'b1, 2, 32'd22, 1'b0, 1'b0);
    end
    rdy = 1'b1;
    #2 chk("bp.release.gnt", 32'(gnt), 32'b1000);
    @(posedge clk); #1;
    chk_rsp("bp.release", 1'b1, 3, 32'd33, 1'b0, 1'b0);

    // Asynchronous reset while a result is held.
    #2 rst_n = 1'b0;
    #1;
    chk("rst.mid.valid", 32'(rsp_valid), 32'd0);
    chk("rst.mid.gnt", 32'(gnt), 32'd0);
    chk("rst.mid.sum", rsp_sum, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("rst.held.gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst.after.gnt", 32'(gnt), 32'b0001);
    @(posedge clk); #1;
    chk_rsp("rst.after", 1'b1, 0, 32'd0, 1'b0, 1'b0);

`ifdef ADDER_ARBITER_SUB_EN
    req = 4'b1000; sub_drv = 4'b1000;
    a_drv[3] = 32'd5; b_drv[3] = 32'd7;
    #2 chk("sub.gnt", 32'(gnt), 32'b1000);
    @(posedge clk); #1;
    chk_rsp("sub", 1'b1, 3, 32'hFFFF_FFFE, 1'b0, 1'b0);
    sub_drv = '0;
`endif

    // Randomized traffic against the reference model, from a fresh reset.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_valid = 1'b0; m_id = 0; m_sum = '0; m_c = 1'b0; m_o = 1'b0; m_last = NR - 1;
    for (int t = 0; t < 400; t++) begin
      req = NR'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        case ($urandom_range(0, 5))
          0:       a_drv[i] = 32'h7FFF_FFFF;
          1:       a_drv[i] = 32'hFFFF_FFFF;
          default: a_drv[i] = $urandom;
        endcase
        b_drv[i] = ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom;
      end
`ifdef ADDER_ARBITER_SUB_EN
      sub_drv = NR'($urandom_range(0, 15));
`endif
      g = (!m_valid || rdy) ? pick(req, m_last) : -1;
      egnt = (g >= 0) ? NR'(1 << g) : '0;
      #2 chk($sformatf("rnd%0d.gnt", t), 32'(gnt), 32'(egnt));
      if (g >= 0) begin
        s_bit = 1'b0;
`ifdef ADDER_ARBITER_SUB_EN
        s_bit = sub_drv[g];
`endif
        ref_op(a_drv[g], b_drv[g], s_bit, m_sum, m_c, m_o);
        m_valid = 1'b1; m_id = g; m_last = g;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk_rsp($sformatf("rnd%0d", t), m_valid, m_id, m_sum, m_c, m_o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
